// File: rtl/seq_detect_110101_pkg.sv
// Shared types and constants for the 110101 serial pattern detector.
// States Sn record the longest pattern prefix seen as a suffix of the input.
package seq_detect_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_e;

    localparam logic [5:0] PATTERN     = 6'b110101;
    localparam int         PATTERN_LEN = 6;

endpackage

// File: rtl/seq_detect_110101_if.sv
// Serial bit-in / flag-out bundle for the pattern detector.
// The master drives data bits; the slave (detector) returns the flag.
interface seq_detect_110101_if;

    logic d_in;
    logic q_out;

    modport master (
        output d_in,
        input  q_out
    );

    modport slave (
        input  d_in,
        output q_out
    );

endinterface

// File: rtl/seq_detect_110101.sv
// Moore detector for the overlapping serial pattern 110101.
// q_out is registered alongside the state, so it is high only while in S6.
module seq_detect_110101
    import seq_detect_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    seq_detect_110101_if.slave  bus
);

    state_e r_state;
    state_e w_next;
    logic   r_q;

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = bus.d_in ? S1 : S0;
            S1:      w_next = bus.d_in ? S2 : S0;
            S2:      w_next = bus.d_in ? S2 : S3;
            S3:      w_next = bus.d_in ? S4 : S0;
            S4:      w_next = bus.d_in ? S2 : S5;
            S5:      w_next = bus.d_in ? S6 : S0;
            // A trailing 1 after a match keeps "11" as a live prefix
            S6:      w_next = bus.d_in ? S2 : S0;
            default: w_next = S0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S0;
            r_q     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_q     <= (w_next == S6);
        end
    end

    assign bus.q_out = r_q;

endmodule

// File: tb/tb_seq_detect_110101.sv
// Bench for seq_detect_110101: directed and random bit streams checked
// against a six-bit history model, with literal pulse-count expectations.
module tb_seq_detect_110101;

    logic clk;
    logic rst_n;

    seq_detect_110101_if u_if();

    seq_detect_110101 dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int pulses[$];

    logic [5:0] hist;
    int         nbits;

    function automatic logic model_flag();
        return (nbits >= 6) && (hist == 6'b110101);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (u_if.q_out === 1'b1) pulses.push_back(cyc);
        chk("q_out_vs_model", {31'd0, u_if.q_out}, {31'd0, model_flag()});
    end

    task automatic model_reset();
        hist  = 6'd0;
        nbits = 0;
    endtask

    task automatic step(input logic b);
        u_if.d_in = b;
        @(posedge clk);
        if (rst_n) begin
            hist = {hist[4:0], b};
            if (nbits < 64) nbits++;
        end
        #1;
    endtask

    task automatic send(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(v[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step(1'b1);
        step(1'b0);
        rst_n = 1'b1;
    endtask

    int p0;
    int p_first;

    initial begin
        rst_n     = 1'b0;
        u_if.d_in = 1'b0;
        model_reset();

        // Reset held with toggling input: flag must stay low
        for (int i = 0; i < 8; i++) step(i[0]);
        chk("reset_hold_q", {31'd0, u_if.q_out}, 32'd0);
        rst_n = 1'b1;

        // Basic match
        do_reset();
        p0 = pulses.size();
        send(16'b110101, 6);
        step(1'b0);
        chk("basic_count", pulses.size() - p0, 32'd1);

        // Two matches separated by one gap bit
        do_reset();
        p0 = pulses.size();
        send(16'b1101010110101, 13);
        step(1'b0);
        chk("gap_count", pulses.size() - p0, 32'd2);
        if (pulses.size() - p0 == 2)
            chk("gap_spacing", pulses[p0 + 1] - pulses[p0], 32'd7);

        // Overlapping matches
        do_reset();
        p0 = pulses.size();
        send(16'b11010110101, 11);
        step(1'b0);
        chk("overlap_count", pulses.size() - p0, 32'd2);
        if (pulses.size() - p0 == 2)
            chk("overlap_spacing", pulses[p0 + 1] - pulses[p0], 32'd5);

        // Near misses
        do_reset();
        p0 = pulses.size();
        send(16'b11011, 5);
        do_reset();
        send(16'b1100101, 7);
        do_reset();
        send(16'b110100, 6);
        do_reset();
        send(16'b111010, 6);
        step(1'b0);
        chk("near_miss_count", pulses.size() - p0, 32'd0);

        // 111010 followed by 1 still matches
        do_reset();
        p0 = pulses.size();
        send(16'b1110101, 7);
        step(1'b0);
        chk("retain_11_count", pulses.size() - p0, 32'd1);

        // Async reset while in S5, then a 1 must not detect
        do_reset();
        p0 = pulses.size();
        send(16'b11010, 5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_s5_q", {31'd0, u_if.q_out}, 32'd0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b1);
        step(1'b0);
        chk("async_s5_count", pulses.size() - p0, 32'd0);

        // Async reset clears a live flag without a clock edge
        do_reset();
        send(16'b110101, 6);
        #1;
        chk("pre_async_q", {31'd0, u_if.q_out}, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_clear_q", {31'd0, u_if.q_out}, 32'd0);
        step(1'b0);
        rst_n = 1'b1;

        // Long random stream
        do_reset();
        p0 = pulses.size();
        for (int i = 0; i < 1200; i++) step(1'($urandom_range(1, 0)));
        step(1'b0);
        p_first = pulses.size() - p0;
        if (p_first == 0)
            chk("random_has_pulses", 32'd0, 32'd1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
